// File: rtl/adc_scan_sequencer.sv
// Scan controller for an Avalon-ST ADC core: walks NUM_CH slots, averages 2**AVG_LOG2 samples per slot.
// Define ADC_SEQ_THRESHOLD_EN to build the per-slot sticky threshold alarms.
module adc_scan_sequencer #(
  parameter int NUM_CH      = 8,
  parameter int CH_W        = 5,
  parameter int DATA_W      = 12,
  parameter int AVG_LOG2    = 2,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     continuous,
  input  logic [NUM_CH*CH_W-1:0]   ch_list,
  output logic                     cmd_valid,
  output logic [CH_W-1:0]          cmd_channel,
  output logic                     cmd_sop,
  output logic                     cmd_eop,
  input  logic                     cmd_ready,
  input  logic                     rsp_valid,
  input  logic [CH_W-1:0]          rsp_channel,
  input  logic [DATA_W-1:0]        rsp_data,
  input  logic [3:0]               rd_idx,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     busy,
  output logic                     scan_done,
  output logic                     err_timeout,
  output logic                     err_mismatch,
  input  logic [DATA_W-1:0]        thresh_hi,
  output logic [NUM_CH-1:0]        alarm
);

  localparam int SLOT_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int ACC_W  = DATA_W + AVG_LOG2;
  localparam int CNT_W  = AVG_LOG2 + 1;
  localparam int NSMP   = 1 << AVG_LOG2;
  localparam int TMR_W  = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_ACC,
    S_NEXT
  } state_t;

  state_t              state_reg;
  state_t              state_next;
  logic [SLOT_W-1:0]   slot_reg;
  logic [CH_W-1:0]     cur_ch_reg;
  logic [CNT_W-1:0]    smp_cnt_reg;
  logic [ACC_W-1:0]    acc_reg;
  logic [TMR_W-1:0]    timer_reg;
  logic                stop_reg;
  logic                cont_reg;
  logic                skip_reg;
  logic                scan_done_reg;
  logic                err_timeout_reg;
  logic                err_mismatch_reg;
  logic [DATA_W-1:0]   result_reg [NUM_CH];

  logic                stop_pend;
  logic                rsp_hit;
  logic                tmo;
  logic                last_smp;
  logic                last_slot;
  logic                wr_en;
  logic [SLOT_W-1:0]   slot_inc;
  logic [DATA_W-1:0]   avg;

  assign stop_pend = stop_reg | stop;
  assign rsp_hit   = rsp_valid && (rsp_channel == cur_ch_reg);
  assign tmo       = (timer_reg == TMR_W'(TIMEOUT_CYC - 1));
  assign last_smp  = (smp_cnt_reg == CNT_W'(NSMP - 1));
  assign last_slot = (slot_reg == SLOT_W'(NUM_CH - 1));
  assign slot_inc  = last_slot ? '0 : slot_reg + 1'b1;
  assign avg       = acc_reg[AVG_LOG2 +: DATA_W];
  // A timed-out slot or an aborted pass leaves the stored result untouched.
  assign wr_en     = (state_reg == S_NEXT) && !skip_reg && !stop_pend;

  assign cmd_valid    = (state_reg == S_ISSUE);
  assign cmd_channel  = cur_ch_reg;
  assign cmd_sop      = cmd_valid;
  assign cmd_eop      = cmd_valid;
  assign busy         = (state_reg != S_IDLE);
  assign scan_done    = scan_done_reg;
  assign err_timeout  = err_timeout_reg;
  assign err_mismatch = err_mismatch_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) state_next = S_ISSUE;
      end
      S_ISSUE: begin
        // An accepted command must still get its response before aborting.
        if (cmd_ready)      state_next = S_WAIT;
        else if (stop_pend) state_next = S_IDLE;
      end
      S_WAIT: begin
        if (rsp_hit || tmo) begin
          if (stop_pend)    state_next = S_IDLE;
          else if (rsp_hit) state_next = S_ACC;
          else              state_next = S_NEXT;
        end
      end
      S_ACC: begin
        if (stop_pend)     state_next = S_IDLE;
        else if (last_smp) state_next = S_NEXT;
        else               state_next = S_ISSUE;
      end
      S_NEXT: begin
        if (stop_pend)                  state_next = S_IDLE;
        else if (!last_slot || cont_reg) state_next = S_ISSUE;
        else                            state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_reg         <= '0;
      cur_ch_reg       <= '0;
      smp_cnt_reg      <= '0;
      acc_reg          <= '0;
      timer_reg        <= '0;
      stop_reg         <= 1'b0;
      cont_reg         <= 1'b0;
      skip_reg         <= 1'b0;
      scan_done_reg    <= 1'b0;
      err_timeout_reg  <= 1'b0;
      err_mismatch_reg <= 1'b0;
    end else begin
      scan_done_reg <= 1'b0;
      // Start wins over a simultaneous stop, so stop is only latched once busy.
      if (state_reg == S_IDLE || state_next == S_IDLE) stop_reg <= 1'b0;
      else if (stop)                                   stop_reg <= 1'b1;

      case (state_reg)
        S_IDLE: begin
          if (start) begin
            slot_reg         <= '0;
            cur_ch_reg       <= ch_list[CH_W-1:0];
            smp_cnt_reg      <= '0;
            acc_reg          <= '0;
            skip_reg         <= 1'b0;
            cont_reg         <= continuous;
            err_timeout_reg  <= 1'b0;
            err_mismatch_reg <= 1'b0;
          end
        end
        S_ISSUE: timer_reg <= '0;
        S_WAIT: begin
          timer_reg <= timer_reg + 1'b1;
          if (rsp_valid && !rsp_hit) err_mismatch_reg <= 1'b1;
          if (rsp_hit) begin
            acc_reg <= acc_reg + ACC_W'(rsp_data);
          end else if (tmo) begin
            err_timeout_reg <= 1'b1;
            acc_reg         <= '0;
            skip_reg        <= 1'b1;
          end
        end
        S_ACC: begin
          if (!last_smp) smp_cnt_reg <= smp_cnt_reg + 1'b1;
        end
        S_NEXT: begin
          acc_reg     <= '0;
          smp_cnt_reg <= '0;
          skip_reg    <= 1'b0;
          if (!stop_pend) begin
            slot_reg   <= slot_inc;
            cur_ch_reg <= ch_list[int'(slot_inc)*CH_W +: CH_W];
            if (last_slot) scan_done_reg <= 1'b1;
          end
        end
        default: ;
      endcase

      // Any abort discards the partial average.
      if (state_reg != S_IDLE && state_next == S_IDLE) begin
        acc_reg     <= '0;
        smp_cnt_reg <= '0;
        skip_reg    <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_CH; k++) result_reg[k] <= '0;
    end else if (wr_en) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (slot_reg == SLOT_W'(k)) result_reg[k] <= avg;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (rd_idx == 4'(k)) rd_data = result_reg[k];
    end
  end

`ifdef ADC_SEQ_THRESHOLD_EN
  logic [NUM_CH-1:0] alarm_reg;
  logic              over;

  assign over  = (avg > thresh_hi);
  assign alarm = alarm_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alarm_reg <= '0;
    end else if (state_reg == S_IDLE && start) begin
      alarm_reg <= '0;
    end else if (wr_en) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (slot_reg == SLOT_W'(k)) alarm_reg[k] <= alarm_reg[k] | over;
      end
    end
  end
`else
  logic unused_thresh;

  assign unused_thresh = ^thresh_hi;
  assign alarm         = '0;
`endif

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Directed bench for adc_scan_sequencer: table-checked results plus multi-cycle corner sequences.
module tb_adc_scan_sequencer;

  localparam int NUM_CH  = 4;
  localparam int CH_W    = 5;
  localparam int DATA_W  = 12;
  localparam int TMO     = 20;
  localparam int RSP_LAT = 2;

  logic                   clk = 1'b0;
  logic                   reset_n = 1'b0;
  logic                   start = 1'b0;
  logic                   stop = 1'b0;
  logic                   continuous = 1'b0;
  logic [NUM_CH*CH_W-1:0] ch_list = {5'd3, 5'd2, 5'd1, 5'd0};
  logic                   cmd_valid;
  logic [CH_W-1:0]        cmd_channel;
  logic                   cmd_sop;
  logic                   cmd_eop;
  logic                   cmd_ready;
  logic                   rsp_valid;
  logic [CH_W-1:0]        rsp_channel;
  logic [DATA_W-1:0]      rsp_data;
  logic [3:0]             rd_idx = 4'd0;
  logic [DATA_W-1:0]      rd_data;
  logic                   busy;
  logic                   scan_done;
  logic                   err_timeout;
  logic                   err_mismatch;
  logic [DATA_W-1:0]      thresh_hi = 12'd500;
  logic [NUM_CH-1:0]      alarm;

  adc_scan_sequencer #(
    .NUM_CH(NUM_CH), .CH_W(CH_W), .DATA_W(DATA_W), .AVG_LOG2(2), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .continuous(continuous),
    .ch_list(ch_list), .cmd_valid(cmd_valid), .cmd_channel(cmd_channel), .cmd_sop(cmd_sop),
    .cmd_eop(cmd_eop), .cmd_ready(cmd_ready), .rsp_valid(rsp_valid), .rsp_channel(rsp_channel),
    .rsp_data(rsp_data), .rd_idx(rd_idx), .rd_data(rd_data), .busy(busy), .scan_done(scan_done),
    .err_timeout(err_timeout), .err_mismatch(err_mismatch), .thresh_hi(thresh_hi), .alarm(alarm)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // ADC model state and monitor counters
  int cyc = 0, pend = 0, hold_cnt = 0, ready_hold = 0;
  int drop_ch = -1, mism_ch = -1, drop_cyc = -1, tmo_cyc = -1;
  int xfers = 0, done_cnt = 0, stab_bad = 0, sop_bad = 0, stall_seen = 0;
  int base [32];
  int cnt  [32];
  logic [CH_W-1:0] xfer_ch = '0;
  logic [CH_W-1:0] prev_ch = '0;
  logic            prev_v = 1'b0;

  typedef struct {
    int          phase;
    logic [3:0]  idx;
    logic [11:0] exp;
  } rd_vec_t;
  rd_vec_t tbl [14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end else begin
      $display("ok   %s: %0d", nm, act);
    end
  endtask

  task automatic check_phase(input int ph);
    foreach (tbl[i]) begin
      if (tbl[i].phase == ph) begin
        rd_idx = tbl[i].idx;
        #1;
        chk($sformatf("p%0d rd_data[%0d]", ph, tbl[i].idx), 32'(rd_data), 32'(tbl[i].exp));
      end
    end
  endtask

  task automatic clr_stats();
    xfers = 0; done_cnt = 0; stab_bad = 0; sop_bad = 0; stall_seen = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    clr_stats();
    drop_ch = -1; mism_ch = -1; drop_cyc = -1; tmo_cyc = -1;
    for (int i = 0; i < 32; i++) begin base[i] = 100; cnt[i] = 0; end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic do_start(input logic cont, input logic with_stop);
    @(negedge clk);
    start = 1'b1; continuous = cont; stop = with_stop;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
  endtask

  task automatic wait_idle(input int max, input string nm);
    int n = 0;
    while (busy && n < max) begin @(negedge clk); n++; end
    chk(nm, 32'(busy), 0);
  endtask

  // ADC model: optional ready stall, fixed response latency, optional drop / wrong-channel injection.
  initial begin
    cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_channel = '0; rsp_data = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset_n) begin
        pend = 0; cmd_ready = 1'b0; rsp_valid = 1'b0; hold_cnt = 0; prev_v = 1'b0;
      end else begin
        rsp_valid = 1'b0;
        if (scan_done) done_cnt++;
        if (err_timeout && tmo_cyc < 0) tmo_cyc = cyc;
        if (cmd_ready) begin
          xfers++;
          if (int'(xfer_ch) == drop_ch) begin
            drop_ch = -1;
            drop_cyc = cyc;
          end else begin
            pend = RSP_LAT;
          end
        end else if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            if (int'(xfer_ch) == mism_ch) begin
              rsp_channel = 5'd7; rsp_data = 12'd4000; mism_ch = -1; pend = 2;
            end else begin
              rsp_channel = xfer_ch;
              rsp_data = 12'(base[xfer_ch] + cnt[xfer_ch] % 4);
              cnt[xfer_ch]++;
            end
            rsp_valid = 1'b1;
          end
        end
        if (cmd_valid) begin
          if (cmd_sop !== 1'b1 || cmd_eop !== 1'b1) sop_bad++;
          if (prev_v && !cmd_ready) begin
            stall_seen++;
            if (cmd_channel !== prev_ch) stab_bad++;
          end
          if (hold_cnt < ready_hold) begin
            cmd_ready = 1'b0; hold_cnt++;
          end else begin
            cmd_ready = 1'b1; xfer_ch = cmd_channel;
          end
        end else begin
          cmd_ready = 1'b0; hold_cnt = 0;
        end
        prev_v = cmd_valid; prev_ch = cmd_channel;
      end
    end
  end

  initial begin
    int n;
    tbl = '{'{1, 4'd0, 12'd101}, '{1, 4'd1, 12'd101}, '{1, 4'd2, 12'd101}, '{1, 4'd3, 12'd101},
            '{1, 4'd4, 12'd0},   '{1, 4'd15, 12'd0},
            '{2, 4'd0, 12'd101}, '{2, 4'd1, 12'd0},   '{2, 4'd2, 12'd101}, '{2, 4'd3, 12'd101},
            '{3, 4'd2, 12'd101},
            '{4, 4'd2, 12'd601}, '{4, 4'd1, 12'd101}, '{4, 4'd3, 12'd101}};

    do_reset();
    chk("reset busy", 32'(busy), 0);
    chk("reset cmd_valid", 32'(cmd_valid), 0);
    chk("reset scan_done", 32'(scan_done), 0);
    chk("reset err_timeout", 32'(err_timeout), 0);
    chk("reset err_mismatch", 32'(err_mismatch), 0);
    chk("reset alarm", 32'(alarm), 0);
    chk("reset rd_data", 32'(rd_data), 0);

    // basic one-shot scan, start and stop together (start wins)
    rd_idx = 4'd3;
    do_start(1'b0, 1'b1);
    chk("start beats stop busy", 32'(busy), 1);
    n = 0;
    while (!scan_done && n < 400) begin @(negedge clk); n++; end
    chk("scan_done seen", 32'(scan_done), 1);
    chk("last result at scan_done", 32'(rd_data), 101);
    wait_idle(50, "basic idle after scan");
    chk("basic scan_done count", done_cnt, 1);
    chk("basic transfers", xfers, 16);
    chk("basic err_timeout", 32'(err_timeout), 0);
    check_phase(1);

    // ready stalled 5 cycles per command
    clr_stats();
    ready_hold = 5;
    do_start(1'b0, 1'b0);
    wait_idle(1000, "stall idle");
    ready_hold = 0;
    chk("stall channel stability errors", stab_bad, 0);
    chk("stall sop/eop errors", sop_bad, 0);
    chk("stall transfers", xfers, 16);
    chk("stall cycles", stall_seen, 80);
    chk("stall scan_done count", done_cnt, 1);

    // dropped response on slot 1
    do_reset();
    drop_ch = 1;
    do_start(1'b0, 1'b0);
    wait_idle(1000, "timeout idle");
    chk("timeout err_timeout", 32'(err_timeout), 1);
    chk("timeout latency", tmo_cyc - drop_cyc, TMO);
    chk("timeout transfers", xfers, 13);
    chk("timeout scan_done count", done_cnt, 1);
    check_phase(2);

    // wrong-channel response for slot 2
    do_reset();
    mism_ch = 2;
    do_start(1'b0, 1'b0);
    wait_idle(1000, "mismatch idle");
    chk("mismatch err_mismatch", 32'(err_mismatch), 1);
    chk("mismatch err_timeout", 32'(err_timeout), 0);
    check_phase(3);

    // threshold pass: slot 2 samples 600..603
    base[2] = 600;
    thresh_hi = 12'd500;
    do_start(1'b0, 1'b0);
    chk("start clears err_mismatch", 32'(err_mismatch), 0);
    wait_idle(1000, "thresh idle");
`ifdef ADC_SEQ_THRESHOLD_EN
    chk("alarm after hot slot", 32'(alarm), 32'h4);
`else
    chk("alarm after hot slot", 32'(alarm), 0);
`endif
    check_phase(4);
    base[2] = 100;
    do_start(1'b0, 1'b0);
    chk("start clears alarm", 32'(alarm), 0);
    wait_idle(1000, "thresh clear idle");
    chk("alarm after cool pass", 32'(alarm), 0);

    // continuous: three passes then stop while waiting for a response
    clr_stats();
    do_start(1'b1, 1'b0);
    n = 0;
    while (done_cnt < 3 && n < 2000) begin @(negedge clk); n++; end
    chk("continuous three passes", done_cnt, 3);
    n = 0;
    while (pend == 0 && n < 100) begin @(negedge clk); n++; end
    chk("continuous reached wait", 32'(pend > 0), 1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    wait_idle(RSP_LAT + 4, "stop in wait idle");
    chk("stop in wait no timeout", 32'(err_timeout), 0);
    repeat (10) @(negedge clk);
    chk("no fourth scan_done", done_cnt, 3);
    chk("stop in wait cmd_valid", 32'(cmd_valid), 0);

    // stop while command is still stalled in ISSUE
    clr_stats();
    ready_hold = 100;
    do_start(1'b0, 1'b0);
    chk("issue cmd_valid", 32'(cmd_valid), 1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("stop in issue cmd_valid", 32'(cmd_valid), 0);
    chk("stop in issue busy", 32'(busy), 0);
    chk("stop in issue transfers", xfers, 0);
    ready_hold = 0;

    // reset mid-scan clears results
    rd_idx = 4'd0;
    do_start(1'b0, 1'b0);
    repeat (30) @(negedge clk);
    chk("pre-reset rd_data", 32'(rd_data), 101);
    reset_n = 1'b0;
    #1;
    chk("mid reset busy", 32'(busy), 0);
    chk("mid reset cmd_valid", 32'(cmd_valid), 0);
    chk("mid reset rd_data", 32'(rd_data), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
